// File: rtl/nib_add_seq.sv
// nib_add_seq: round-robin sequencer serialising WIDTH-bit adds through a shared 4-bit adder (NIB_ADD_SEQ_SUBTRACT_EN adds a-b mode)
module nib_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin0,
    input  logic             cin1,
`ifdef NIB_ADD_SEQ_SUBTRACT_EN
    input  logic             sub0,
    input  logic             sub1,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [3:0]       fa_a,
    output logic [3:0]       fa_b,
    output logic             fa_cin,
    input  logic [3:0]       fa_sum,
    input  logic             fa_cout
);
    localparam int NIB = WIDTH / 4;
    localparam int NW = NIB > 1 ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r, res, res_nxt;
    logic [NW-1:0]    nib;
    logic             carry, sub_r, id_r, prio1, pick1, last, sub_w0, sub_w1;

`ifdef NIB_ADD_SEQ_SUBTRACT_EN
    assign sub_w0 = sub0;
    assign sub_w1 = sub1;
`else
    assign sub_w0 = 1'b0;
    assign sub_w1 = 1'b0;
`endif

    // req1 wins when alone, or when both are up and req0 won last time
    assign pick1 = req1 && (!req0 || prio1);
    assign last  = nib == NW'(NIB - 1);
    assign busy  = state != IDLE;
    assign done  = state == DONE;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state, adder operand muxing, and the result with the current nibble merged in
    always_comb begin
        state_nxt           = state;
        res_nxt             = res;
        res_nxt[nib*4 +: 4] = fa_sum;
        fa_a                = 4'd0;
        fa_b                = 4'd0;
        fa_cin              = 1'b0;
        case (state)
            IDLE: state_nxt = (req0 || req1) ? RUN : IDLE;
            RUN: begin
                state_nxt = last ? DONE : RUN;
                fa_a      = a_r[nib*4 +: 4];
                fa_b      = sub_r ? ~b_r[nib*4 +: 4] : b_r[nib*4 +: 4];
                fa_cin    = carry;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // grant/operand latch in IDLE, nibble capture in RUN, result publish on the last nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            res     <= '0;
            nib     <= '0;
            carry   <= 1'b0;
            sub_r   <= 1'b0;
            id_r    <= 1'b0;
            prio1   <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
            done_id <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            if (state == IDLE && (req0 || req1)) begin
                a_r   <= pick1 ? a1 : a0;
                b_r   <= pick1 ? b1 : b0;
                sub_r <= pick1 ? sub_w1 : sub_w0;
                carry <= pick1 ? (sub_w1 || cin1) : (sub_w0 || cin0);
                id_r  <= pick1;
                prio1 <= !pick1;
                gnt0  <= !pick1;
                gnt1  <= pick1;
                nib   <= '0;
            end
            if (state == RUN) begin
                res   <= res_nxt;
                carry <= fa_cout;
                nib   <= nib + 1'b1;
                if (last) begin
                    sum     <= res_nxt;
                    c_out   <= fa_cout;
                    done_id <= id_r;
                end
            end
        end
    end
endmodule
